drum_mult_pipe: RTL and testbench

Pipelined, parametrised successor of the team's combinational DRUM approximate multiplier. Accepts operand pairs on a valid/ready stream, computes a DRUM-k approximate product (or an exact product, selectable per transaction) with true two's-complement sign handling, and returns the result with a fixed 3-cycle latency. It sits in the CNN MAC datapath between the operand fetch buffers and the accumulator, and supports back-pressure from the accumulator.

---
 rtl/drum_mult_pipe.sv | 258 +++++++++++++++++++++++++
 tb/tb_drum_mult_pipe.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/drum_mult_pipe.sv
// drum_mult_pipe: pipelined DRUM-K approximate / exact multiplier.
// Operand pairs arrive on a valid/ready stream and results leave on another
// valid/ready stream, three clock edges after the accepting edge.
// Signed operands are reduced to magnitudes, multiplied, then sign-restored.
// One enable (w_advance) moves every stage at once. The whole pipe freezes
// only when the output register holds a result the consumer has not taken.

module drum_mult_pipe #(
   parameter int N     = 16,
   parameter int M     = 16,
   parameter int K     = 6,
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [N-1:0]     in_a,
   input  logic [M-1:0]     in_b,
   input  logic             in_signed,
   input  logic             in_approx,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [N+M-1:0]   out_r,
   output logic [TAG_W-1:0] out_tag
);

   localparam int W   = N + M;
   localparam int SHW = $clog2(W + 1);
   localparam logic [SHW-1:0] K_SH = SHW'(K);

   // ------------------------------------------------------------------
   // Helper functions
   // ------------------------------------------------------------------

   // Index of the most significant set bit (0 for a zero input).
   function automatic logic [SHW-1:0] lead_one(input logic [W-1:0] x);
      logic [SHW-1:0] pos;
      pos = '0;
      for (int i = 0; i < W; i++) begin
         if (x[i]) begin
            pos = SHW'(i);
         end
      end
      return pos;
   endfunction

   // DRUM shift amount: 0 when x is zero or its leading one sits below K,
   // otherwise the number of bits dropped under the K-bit window.
   function automatic logic [SHW-1:0] drum_shift(input logic [W-1:0] x);
      logic [SHW-1:0] t;
      logic [SHW-1:0] sh;
      t = lead_one(x);
      if ((x == '0) || (t < K_SH)) begin
         sh = '0;
      end else begin
         sh = t - K_SH + SHW'(1);
      end
      return sh;
   endfunction

   // DRUM mantissa: the K-bit window at the leading one. When bits were
   // dropped, the window LSB is forced to 1 to unbias the truncation.
   function automatic logic [K-1:0] drum_mant(input logic [W-1:0] x,
                                              input logic [SHW-1:0] sh);
      logic [K-1:0] m;
      m = K'(x >> sh);
      if (sh != '0) begin
         m[0] = 1'b1;
      end
      return m;
   endfunction

   // ------------------------------------------------------------------
   // Stall control
   // ------------------------------------------------------------------
   logic w_advance;

   logic             r_out_valid;
   logic [W-1:0]     r_out_r;
   logic [TAG_W-1:0] r_out_tag;

   // Whole pipe moves unless a finished result is waiting on the consumer.
   always_comb begin
      w_advance = (~r_out_valid) | out_ready;
   end

   assign in_ready  = w_advance;
   assign out_valid = r_out_valid;
   assign out_r     = r_out_r;
   assign out_tag   = r_out_tag;

   // ------------------------------------------------------------------
   // S0: capture the raw transaction
   // ------------------------------------------------------------------
   logic             r0_valid;
   logic [N-1:0]     r0_a;
   logic [M-1:0]     r0_b;
   logic             r0_signed;
   logic             r0_approx;
   logic [TAG_W-1:0] r0_tag;

   // Register the accepted operand pair and its per-transaction controls.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r0_valid  <= 1'b0;
         r0_a      <= '0;
         r0_b      <= '0;
         r0_signed <= 1'b0;
         r0_approx <= 1'b0;
         r0_tag    <= '0;
      end else if (w_advance) begin
         r0_valid  <= in_valid;
         r0_a      <= in_a;
         r0_b      <= in_b;
         r0_signed <= in_signed;
         r0_approx <= in_approx;
         r0_tag    <= in_tag;
      end
   end

   // ------------------------------------------------------------------
   // S1: magnitudes, result sign, leading-one detect
   // ------------------------------------------------------------------
   logic           w_neg_a;
   logic           w_neg_b;
   logic [N-1:0]   w_mag_a;
   logic [M-1:0]   w_mag_b;
   logic [SHW-1:0] w_sh_a;
   logic [SHW-1:0] w_sh_b;

   // Two's-complement magnitudes; -2^(N-1) maps to 2^(N-1) in N bits.
   always_comb begin
      w_neg_a = r0_signed & r0_a[N-1];
      w_neg_b = r0_signed & r0_b[M-1];
      if (w_neg_a) begin
         w_mag_a = (~r0_a) + N'(1);
      end else begin
         w_mag_a = r0_a;
      end
      if (w_neg_b) begin
         w_mag_b = (~r0_b) + M'(1);
      end else begin
         w_mag_b = r0_b;
      end
      w_sh_a = drum_shift(W'(w_mag_a));
      w_sh_b = drum_shift(W'(w_mag_b));
   end

   logic             r1_valid;
   logic [N-1:0]     r1_mag_a;
   logic [M-1:0]     r1_mag_b;
   logic [SHW-1:0]   r1_sh_a;
   logic [SHW-1:0]   r1_sh_b;
   logic             r1_neg;
   logic             r1_approx;
   logic [TAG_W-1:0] r1_tag;

   // Register magnitudes, DRUM shift amounts, sign, mode and tag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r1_valid  <= 1'b0;
         r1_mag_a  <= '0;
         r1_mag_b  <= '0;
         r1_sh_a   <= '0;
         r1_sh_b   <= '0;
         r1_neg    <= 1'b0;
         r1_approx <= 1'b0;
         r1_tag    <= '0;
      end else if (w_advance) begin
         r1_valid  <= r0_valid;
         r1_mag_a  <= w_mag_a;
         r1_mag_b  <= w_mag_b;
         r1_sh_a   <= w_sh_a;
         r1_sh_b   <= w_sh_b;
         r1_neg    <= w_neg_a ^ w_neg_b;
         r1_approx <= r0_approx;
         r1_tag    <= r0_tag;
      end
   end

   // ------------------------------------------------------------------
   // S2: mantissas and partial product
   // ------------------------------------------------------------------
   logic [K-1:0]   w_mant_a;
   logic [K-1:0]   w_mant_b;
   logic [W-1:0]   w_pprod;
   logic [SHW-1:0] w_sh_sum;

   // Approx mode multiplies the K-bit mantissas; exact mode the magnitudes.
   always_comb begin
      w_mant_a = drum_mant(W'(r1_mag_a), r1_sh_a);
      w_mant_b = drum_mant(W'(r1_mag_b), r1_sh_b);
      if (r1_approx) begin
         w_pprod  = W'(w_mant_a) * W'(w_mant_b);
         w_sh_sum = r1_sh_a + r1_sh_b;
      end else begin
         w_pprod  = W'(r1_mag_a) * W'(r1_mag_b);
         w_sh_sum = '0;
      end
   end

   logic             r2_valid;
   logic [W-1:0]     r2_prod;
   logic [SHW-1:0]   r2_sh;
   logic             r2_neg;
   logic [TAG_W-1:0] r2_tag;

   // Register the partial product with its pending left shift.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r2_valid <= 1'b0;
         r2_prod  <= '0;
         r2_sh    <= '0;
         r2_neg   <= 1'b0;
         r2_tag   <= '0;
      end else if (w_advance) begin
         r2_valid <= r1_valid;
         r2_prod  <= w_pprod;
         r2_sh    <= w_sh_sum;
         r2_neg   <= r1_neg;
         r2_tag   <= r1_tag;
      end
   end

   // ------------------------------------------------------------------
   // S3: rescale, sign restore, output register
   // ------------------------------------------------------------------
   logic [W-1:0] w_shifted;
   logic [W-1:0] w_result;

   // Shift back to full scale; negating zero stays zero.
   always_comb begin
      w_shifted = r2_prod << r2_sh;
      if (r2_neg) begin
         w_result = (~w_shifted) + W'(1);
      end else begin
         w_result = w_shifted;
      end
   end

   // Output register; data only reloads when a real result arrives.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_out_r     <= '0;
         r_out_tag   <= '0;
      end else if (w_advance) begin
         r_out_valid <= r2_valid;
         if (r2_valid) begin
            r_out_r   <= w_result;
            r_out_tag <= r2_tag;
         end
      end
   end

endmodule

// File: tb/tb_drum_mult_pipe.sv
// Directed self-checking bench for drum_mult_pipe (N=M=16, K=6, TAG_W=4).
module tb_drum_mult_pipe;

   typedef struct packed {
      logic [15:0] a;
      logic [15:0] b;
      logic        s;
      logic        ap;
      logic [31:0] exp;
   } vec_t;

   // Hand-computed DRUM-6 / exact products.
   localparam vec_t VECS [18] = '{
      '{16'd1000,  16'd3,     1'b0, 1'b1, 32'd3024},      // 0  63*3<<4
      '{16'd1000,  16'd3,     1'b0, 1'b0, 32'd3000},      // 1  exact
      '{16'd100,   16'd7,     1'b0, 1'b1, 32'd714},       // 2  t==K: 51*7<<1
      '{16'd63,    16'd64,    1'b0, 1'b1, 32'd4158},      // 3  63*33<<1
      '{16'hFFFF,  16'hFFFF,  1'b0, 1'b1, 32'hF8100000},  // 4  63*63<<20
      '{16'hFFFF,  16'hFFFF,  1'b0, 1'b0, 32'hFFFE0001},  // 5  exact max
      '{16'hFC18,  16'h0003,  1'b1, 1'b1, 32'hFFFFF430},  // 6  -3024
      '{16'hFC18,  16'hFFFD,  1'b1, 1'b1, 32'h00000BD0},  // 7  +3024
      '{16'hFFFF,  16'hFFFF,  1'b1, 1'b0, 32'h00000001},  // 8  -1*-1
      '{16'hFC18,  16'h0003,  1'b1, 1'b0, 32'hFFFFF448},  // 9  -3000
      '{16'h8000,  16'h0001,  1'b1, 1'b1, 32'hFFFF7C00},  // 10 -33792
      '{16'h8000,  16'h8000,  1'b1, 1'b1, 32'h44100000},  // 11 33*33<<20
      '{16'h8000,  16'h8000,  1'b1, 1'b0, 32'h40000000},  // 12 2^30
      '{16'd45,    16'd50,    1'b0, 1'b1, 32'd2250},      // 13 t<K
      '{16'h0000,  16'hFFFD,  1'b1, 1'b1, 32'h00000000},  // 14 zero, neg sign
      '{16'h8000,  16'h0000,  1'b1, 1'b0, 32'h00000000},  // 15 zero, neg sign
      '{16'h0000,  16'h0000,  1'b0, 1'b1, 32'h00000000},  // 16
      '{16'h8000,  16'h0001,  1'b0, 1'b1, 32'h00008400}   // 17 unsigned 0x8000
   };

   localparam int B2B [5] = '{0, 1, 6, 13, 10};

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_a;
   logic [15:0] in_b;
   logic        in_signed;
   logic        in_approx;
   logic [3:0]  in_tag;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_r;
   logic [3:0]  out_tag;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   drum_mult_pipe #(.N(16), .M(16), .K(6), .TAG_W(4)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_signed(in_signed), .in_approx(in_approx),
      .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_r(out_r), .out_tag(out_tag)
   );

   task automatic drive_row(input int i);
      in_a      = VECS[i].a;
      in_b      = VECS[i].b;
      in_signed = VECS[i].s;
      in_approx = VECS[i].ap;
      in_tag    = 4'(i);
      in_valid  = 1'b1;
   endtask

   // Send one pair into an empty pipe and wait (bounded) for its result.
   task automatic run_single(input int i, output logic [31:0] r,
                             output logic [3:0] t, output int lat);
      out_ready = 1'b1;
      drive_row(i);
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      r = out_r;
      t = out_tag;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      in_a = '0; in_b = '0; in_signed = 1'b0; in_approx = 1'b0; in_tag = '0;
      @(posedge clk); #1;
      n_vec++;
      if (out_valid !== 1'b0 || out_r !== 32'd0 || out_tag !== 4'd0) begin
         n_err++;
         $display("FAIL reset_state: valid=%b r=%h tag=%h required 0/0/0", out_valid, out_r, out_tag);
      end
      rst = 1'b0;
      #1;
      n_vec++;
      if (in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL reset_in_ready: got %b required 1", in_ready);
      end
   endtask

   task automatic run_rows(input string name, input int lo, input int hi);
      logic [31:0] r;
      logic [3:0]  t;
      int          lat;
      for (int i = lo; i <= hi; i++) begin
         run_single(i, r, t, lat);
         n_vec++;
         if (r !== VECS[i].exp || t !== 4'(i)) begin
            n_err++;
            $display("FAIL %s row%0d: r=%h tag=%h required r=%h tag=%h", name, i, r, t, VECS[i].exp, 4'(i));
         end
         n_vec++;
         if (lat !== 3) begin
            n_err++;
            $display("FAIL %s row%0d latency: got %0d required 3", name, i, lat);
         end
      end
   endtask

   task automatic test_unsigned();
      run_rows("unsigned", 0, 5);
   endtask

   task automatic test_signed();
      run_rows("signed", 6, 9);
   endtask

   task automatic test_boundary();
      run_rows("boundary", 10, 17);
   endtask

   task automatic test_back_to_back();
      int got   = 0;
      int first = -1;
      out_ready = 1'b1;
      for (int c = 0; c < 10; c++) begin
         if (c < 5) drive_row(B2B[c]);
         else in_valid = 1'b0;
         @(posedge clk); #1;
         if (out_valid) begin
            if (got < 5) begin
               n_vec++;
               if (out_r !== VECS[B2B[got]].exp || out_tag !== 4'(B2B[got])) begin
                  n_err++;
                  $display("FAIL b2b item%0d: r=%h tag=%h required r=%h tag=%h", got, out_r, out_tag,
                           VECS[B2B[got]].exp, 4'(B2B[got]));
               end
            end
            if (first < 0) first = c;
            got++;
         end
      end
      n_vec++;
      if (got !== 5 || first !== 3) begin
         n_err++;
         $display("FAIL b2b count: got %0d results first at cycle %0d required 5 at 3", got, first);
      end
   endtask

   task automatic test_backpressure();
      logic [15:0] pat = 16'b1011_0010_1110_0100;
      logic [31:0] exp_r;
      logic [31:0] held_r = '0;
      logic [3:0]  held_t = '0;
      logic        held_v = 1'b0;
      int sent = 0;
      int rcvd = 0;
      int cyc  = 0;
      int extra = 0;
      while (rcvd < 8 && cyc < 200) begin
         in_valid  = (sent < 8);
         in_a      = 16'(sent * 37 + 5);
         in_b      = 16'(sent + 11);
         in_signed = 1'b0;
         in_approx = 1'b0;
         in_tag    = 4'(sent);
         out_ready = pat[cyc % 16];
         #3;
         if (held_v) begin
            n_vec++;
            if (out_valid !== 1'b1 || out_r !== held_r || out_tag !== held_t) begin
               n_err++;
               $display("FAIL bp_hold: valid=%b r=%h tag=%h required 1 r=%h tag=%h", out_valid, out_r, out_tag,
                        held_r, held_t);
            end
         end
         n_vec++;
         if (in_ready !== (!out_valid || out_ready)) begin
            n_err++;
            $display("FAIL bp_in_ready: got %b required %b", in_ready, (!out_valid || out_ready));
         end
         held_v = out_valid && !out_ready;
         held_r = out_r;
         held_t = out_tag;
         if (out_valid && out_ready) begin
            exp_r = 32'((rcvd * 37 + 5) * (rcvd + 11));
            n_vec++;
            if (out_r !== exp_r || out_tag !== 4'(rcvd)) begin
               n_err++;
               $display("FAIL bp_data item%0d: r=%h tag=%h required r=%h tag=%h", rcvd, out_r, out_tag, exp_r,
                        4'(rcvd));
            end
            rcvd++;
         end
         if (in_valid && in_ready) sent++;
         @(posedge clk); #1;
         cyc++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(posedge clk); #1;
         if (out_valid) extra++;
      end
      n_vec++;
      if (rcvd !== 8 || extra !== 0) begin
         n_err++;
         $display("FAIL bp_count: received %0d extra %0d required 8 and 0", rcvd, extra);
      end
   endtask

   task automatic test_reset_midstream();
      logic [31:0] r;
      logic [3:0]  t;
      int          lat;
      int          stale = 0;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive_row(i);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      n_vec++;
      if (out_valid !== 1'b1 || out_r !== VECS[0].exp) begin
         n_err++;
         $display("FAIL rst_mid_pre: valid=%b r=%h required 1 r=%h", out_valid, out_r, VECS[0].exp);
      end
      #2 rst = 1'b1;
      #1;
      n_vec++;
      if (out_valid !== 1'b0 || out_r !== 32'd0 || out_tag !== 4'd0) begin
         n_err++;
         $display("FAIL rst_mid_async: valid=%b r=%h tag=%h required 0/0/0", out_valid, out_r, out_tag);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      for (int c = 0; c < 8; c++) begin
         @(posedge clk); #1;
         if (out_valid) stale++;
      end
      n_vec++;
      if (stale !== 0) begin
         n_err++;
         $display("FAIL rst_mid_stale: got %0d stale results required 0", stale);
      end
      run_single(13, r, t, lat);
      n_vec++;
      if (r !== VECS[13].exp || lat !== 3) begin
         n_err++;
         $display("FAIL rst_mid_first: r=%h lat=%0d required r=%h lat=3", r, lat, VECS[13].exp);
      end
   endtask

   initial begin
      test_reset();
      test_unsigned();
      test_signed();
      test_boundary();
      test_back_to_back();
      test_backpressure();
      test_reset_midstream();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
